// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
//
// Shared definitions for the AES result path.
//
// Contents:
//   AES_DATASIZE : default block width in bits (one AES state block).
//   tx_state_e   : state encoding of the result_tx serialiser.
//
// Optional feature macro: RESULT_TX_PARITY_EN
//   When it is defined, the enum gains the TX_PARITY state. That state sends
//   one trailing even-parity bit after the data bits.
//   When it is not defined, the state does not exist at all.
// -----------------------------------------------------------------------------
package aes_pkg;

  localparam int AES_DATASIZE = 128;

`ifdef RESULT_TX_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_READY  = 3'd1,
    TX_SHIFT  = 3'd2,
    TX_PARITY = 3'd3,
    TX_DONE   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_READY = 2'd1,
    TX_SHIFT = 2'd2,
    TX_DONE  = 2'd3
  } tx_state_e;
`endif

endpackage : aes_pkg

// File: rtl/result_tx_if.sv
// -----------------------------------------------------------------------------
// result_tx_if
//
// Bundles the signals between result_tx and its environment.
//
// Two parties drive the inputs:
//   - the cipher stage drives load and data_in;
//   - the external serial master drives cs.
// The serialiser drives the status outputs and the serial line.
//
// Signals:
//   load     : one-cycle strobe; data_in is valid in this cycle
//   data_in  : DATASIZE-bit result block
//   cs       : active-low chip select; low consumes one bit per cycle
//   miso     : serial data, MSB first
//   busy     : high while a block is in flight, through the DONE cycle
//   done     : one-cycle pulse after the last bit has been consumed
//   overrun  : sticky flag; set when a load arrives while the block is busy
//
// Modports:
//   master : the environment side (cipher and serial master)
//   slave  : the result_tx side
// -----------------------------------------------------------------------------
interface result_tx_if
  import aes_pkg::*;
#(
  parameter int DATASIZE = AES_DATASIZE
);

  logic                load;
  logic [DATASIZE-1:0] data_in;
  logic                cs;
  logic                miso;
  logic                busy;
  logic                done;
  logic                overrun;

  modport master (
    output load,
    output data_in,
    output cs,
    input  miso,
    input  busy,
    input  done,
    input  overrun
  );

  modport slave (
    input  load,
    input  data_in,
    input  cs,
    output miso,
    output busy,
    output done,
    output overrun
  );

endinterface : result_tx_if

// File: rtl/result_tx.sv
// -----------------------------------------------------------------------------
// result_tx
//
// Serialises one cipher result block onto a chip-selected serial line.
//
// Operation:
//   - A load pulse in IDLE captures data_in.
//   - Each clock edge with cs low consumes the bit currently on miso.
//   - Bits leave MSB first.
//   - cs high pauses the transfer indefinitely. There is no timeout.
//   - After the last bit, DONE lasts one cycle. In that cycle done pulses.
//   - The FSM then returns to IDLE and can accept the next block at once.
//   - A load that arrives while a block is in flight is dropped.
//     The dropped load sets the sticky overrun flag.
//
// Parameters:
//   DATASIZE : block width in bits (at least 2); default from aes_pkg.
//
// Ports:
//   clk : system clock; all state changes on its rising edge
//   rst : synchronous, active-low reset; it overrides load and cs
//   bus : result_tx_if.slave; carries load, data_in, cs, miso, busy,
//         done and overrun
//
// Optional feature macro: RESULT_TX_PARITY_EN
//   When it is defined:
//     - the even parity (XOR) of the block is stored at load;
//     - the PARITY state sends that bit as an extra cs-low cycle after the
//       data bits.
//   When it is not defined, neither the state nor the register exists.
// -----------------------------------------------------------------------------
module result_tx
  import aes_pkg::*;
#(
  parameter int DATASIZE = AES_DATASIZE
) (
  input  logic       clk,
  input  logic       rst,
  result_tx_if.slave bus
);

  localparam int            CNT_W    = $clog2(DATASIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATASIZE - 1);

  tx_state_e           state_q, state_d;
  logic [DATASIZE-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic                ovr_q,   ovr_d;
`ifdef RESULT_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  // ---------------------------------------------------------------------------
  // State register.
  // Reset also clears the shift register, so no trace of an aborted block
  // survives reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= TX_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      ovr_q    <= 1'b0;
`ifdef RESULT_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every register here sample the
      // pre-edge value of the others, which is what a flop does.
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      ovr_q    <= ovr_d;
`ifdef RESULT_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // A cycle with cs high falls through every branch, so all the _d defaults
  // (hold) apply. That is how a pause keeps the block, the counter and the
  // state unchanged.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every _d gets a default before the case. A path that leaves one
    // unassigned would infer a latch.
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    ovr_d    = ovr_q;
`ifdef RESULT_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      TX_IDLE: begin
        if (bus.load) begin
          shreg_d  = bus.data_in;
          cnt_d    = '0;
          ovr_d    = 1'b0;
`ifdef RESULT_TX_PARITY_EN
          parity_d = ^bus.data_in;
`endif
          state_d  = TX_READY;
        end
      end

      TX_READY, TX_SHIFT: begin
        if (!bus.cs) begin
          shreg_d = {shreg_q[DATASIZE-2:0], 1'b0};
          // On the last bit the counter is left at DATASIZE-1 rather than
          // incremented. It therefore never wraps inside a transfer, and the
          // next load clears it anyway.
          if (cnt_q == CNT_LAST) begin
`ifdef RESULT_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_DONE;
`endif
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = TX_SHIFT;
          end
        end
      end

`ifdef RESULT_TX_PARITY_EN
      TX_PARITY: begin
        if (!bus.cs) begin
          state_d = TX_DONE;
        end
      end
`endif

      TX_DONE: begin
        state_d = TX_IDLE;
      end

      default: begin
        state_d = TX_IDLE;
      end
    endcase

    // Any load outside IDLE is dropped. The block in flight is untouched,
    // and the drop is remembered until the next accepted load.
    if (bus.load && (state_q != TX_IDLE)) begin
      ovr_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // All outputs are decoded from registered state only, so miso is stable
  // for the whole cycle in which the master samples it.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.miso = 1'b0;
    case (state_q)
      TX_READY, TX_SHIFT: bus.miso = shreg_q[DATASIZE-1];
`ifdef RESULT_TX_PARITY_EN
      TX_PARITY:          bus.miso = parity_q;
`endif
      default:            bus.miso = 1'b0;
    endcase
  end

  assign bus.busy    = (state_q != TX_IDLE);
  assign bus.done    = (state_q == TX_DONE);
  assign bus.overrun = ovr_q;

endmodule : result_tx

// File: doc/result_tx.md
RESULT_TX -- requirements
Module: result_tx

Interface
REQ-001 SHALL have parameter DATASIZE, default 128, meaning the block width in bits, shifted out per transfer.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port load, input, 1, one-cycle strobe marking data_in valid (driven by the cipher's completion).
REQ-005 SHALL have port data_in, input, DATASIZE, result block from the Cipher stage.
REQ-006 SHALL have port cs, input, 1, active-low chip select from the external master; low means consume one bit this cycle.
REQ-007 SHALL have port miso, output, 1, serial result, MSB first.
REQ-008 SHALL have port busy, output, 1, high from accepted load until the end of the DONE state.
REQ-009 SHALL have port done, output, 1, one-cycle pulse after the last bit is consumed.
REQ-010 SHALL have port overrun, output, 1, sticky flag for a load that was rejected.

Function
REQ-011 SHALL implement a registered FSM with states IDLE, READY, SHIFT, PARITY (macro only) and DONE.
REQ-012 SHALL, in IDLE with load=1, capture data_in into the shift register, clear the bit counter, clear overrun and enter READY next cycle.
REQ-013 SHALL drive miso combinationally as shift_reg[DATASIZE-1] in READY/SHIFT, the parity bit in PARITY, and 0 in IDLE/DONE.
REQ-014 SHALL, in READY or SHIFT on a clock edge with cs=0, shift left by one (LSB fill 0), increment the counter and move READY->SHIFT.
REQ-015 SHALL hold shift register, counter and state unchanged on any cycle with cs=1 (pause, no timeout).
REQ-016 SHALL leave SHIFT after the DATASIZE-th consumed bit (counter = DATASIZE-1 with cs=0): go to PARITY if the macro is defined, else to DONE.
REQ-017 SHALL use a counter of $clog2(DATASIZE) bits; it SHALL never wrap within a transfer.
REQ-018 SHALL hold done=1 for exactly the one DONE cycle, then return to IDLE unconditionally.
REQ-019 SHALL ignore load in READY/SHIFT/PARITY/DONE, keep the current block intact, and set overrun=1 until the next accepted load or reset.
REQ-020 SHALL accept load in the IDLE cycle immediately following DONE (zero-gap back-to-back).
REQ-021 SHALL drive busy=1 in every state except IDLE.
REQ-022 SHALL make the end-to-end transfer DATASIZE cs-low cycles (DATASIZE+1 with macro), plus one load cycle and one DONE cycle.

Reset
REQ-023 SHALL, when rst=0 at a clock edge, enter IDLE and clear shift register, counter, parity, miso, busy, done and overrun to 0, aborting any transfer in progress.
REQ-024 SHALL give rst priority over load and cs in the same cycle.

Configuration
REQ-025 SHALL, with RESULT_TX_PARITY_EN defined, store even parity (XOR of data_in) at load and present it in PARITY for one cs-low cycle before DONE.
REQ-026 SHALL, without RESULT_TX_PARITY_EN, omit the PARITY state and its register entirely; DONE follows the last data bit.

Structure
REQ-027 SHALL take the FSM state enum and the default DATASIZE constant from the shared aes_pkg package.
REQ-028 SHALL be a single module with no sub-modules; the shift register, counter and FSM are inline.

Verification
REQ-029 SHALL cover: load data_in=128'h3925841d02dc09fbdc118597196a0b32, cs low 128 cycles -> miso MSB-first reproduces the value, done pulses once, busy then falls.
REQ-030 SHALL cover: same block with cs toggled high every 3rd cycle -> identical bit stream, 128 consumed bits, done after the last one.
REQ-031 SHALL cover: second load at bit 40 -> overrun=1, stream continues with the original block; next accepted load clears overrun.
REQ-032 SHALL cover: rst=0 at bit 64 -> next cycle IDLE, miso=0, busy=0, done never pulses; a fresh load transfers correctly.
REQ-033 SHALL cover: load on the IDLE cycle right after done -> accepted, no overrun, second block streams with no gap.
REQ-034 SHALL cover, with RESULT_TX_PARITY_EN, data_in=128'h1 -> 129th bit is 1, done one cycle later; data_in=128'h3 -> 129th bit is 0.
